pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Central sequencer for the five-stage MIPS pipeline. Generates per-stage advance, flush and bubble controls from the decoded fields of the instruction in ID and the load in EX. Runs the debug-facing run/step/halt state machine: free-running execution, single-cycle stepping, and draining the pipeline after a HALT is decoded. Sits between the debug unit, the instruction decoder's flag outputs, and the PC, IF/ID and ID/EX registers.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles the pipe keeps advancing after HALT leaves ID (EX, MEM, WB)
- COUNT_W, 32, width of the executed-cycle counter

Ports (clock and reset first):
- i_clk  in  1  single system clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_run  in  1  level; high = free-run requested
- i_step  in  1  one-cycle pulse; request one pipeline advance
- i_id_halt  in  1  instruction in ID is HALT (opcode 6'b111111)
- i_id_rs  in  5  rs field of instruction in ID
- i_id_rt  in  5  rt field of instruction in ID
- i_id_uses_rt  in  1  ID instruction reads rt (R-type, branch, store)
- i_id_branch_taken  in  1  jump or branch resolved taken in ID
- i_ex_mem_op  in  1  EX instruction is a memory op
- i_ex_mem_type  in  1  EX memory op type: 0 load, 1 store
- i_ex_rt  in  5  destination rt of EX instruction
- o_pc_en  out  1  PC loads next value
- o_if_id_en  out  1  IF/ID register captures
- o_if_id_flush  out  1  IF/ID register loads NOP
- o_id_ex_bubble  out  1  ID/EX register loads NOP
- o_pipe_en  out  1  ID/EX, EX/MEM, MEM/WB registers advance
- o_state  out  3  current FSM state encoding
- o_halted  out  1  program finished and pipeline drained
- o_cycle_count  out  COUNT_W  number of cycles with o_pipe_en=1

## Operation
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4.
- Advance flag adv = (state==RUN || state==STEP).
- IDLE: all enables 0. i_run -> RUN. Else i_step -> STEP. If both are high, RUN wins.
- RUN: adv. !i_run -> IDLE.
- STEP: adv for exactly one cycle, then -> IDLE, unless HALT causes a transition to DRAIN.
- Load-use hazard lu = i_ex_mem_op & !i_ex_mem_type & (i_ex_rt!=0) & (i_ex_rt==i_id_rs | (i_id_uses_rt & i_ex_rt==i_id_rt)).
- When adv & lu: o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1, o_pipe_en=1. HALT and branch are ignored that cycle.
- When adv & !lu & i_id_branch_taken: o_pc_en=1 (PC takes target), o_if_id_flush=1, o_pipe_en=1.
- When adv & !lu & i_id_halt:
  - Outputs: o_pc_en=0, o_if_id_flush=1, o_pipe_en=1.
  - Next state DRAIN, drain counter loaded with DRAIN_CYCLES.
  - HALT has priority over i_run falling and over STEP returning to IDLE.
- When adv with no other condition: o_pc_en=o_if_id_en=o_pipe_en=1.
- DRAIN:
  - Outputs: o_pipe_en=1, o_pc_en=0, o_if_id_en=0, o_if_id_flush=1.
  - Counter decrements each cycle. Counter==1 -> DONE.
  - i_run and i_step are ignored.
- DONE: all enables 0, o_halted=1. Terminal until reset.
- o_cycle_count increments by 1 on every edge where o_pipe_en=1. It wraps modulo 2^COUNT_W.

## Timing
- Reset (asynchronous, i_rst_n=0): state=IDLE, drain counter=0, o_cycle_count=0. All enables, flush and bubble = 0. o_halted=0, o_state=0.
- Control outputs are combinational from the registered state and current inputs. State and counters update on the rising edge.
- i_run is sampled at an edge. Execution starts the cycle after i_run is sampled high and stops the cycle after i_run is sampled low (one-cycle lag).
- i_step yields exactly one cycle of o_pipe_en=1, which may be a bubble cycle.
- i_step pulses arriving while in RUN, STEP, DRAIN or DONE are dropped.
- Drain length: exactly DRAIN_CYCLES cycles in DRAIN, then DONE on the following edge.
- Reset mid-DRAIN or mid-DONE returns to IDLE immediately.

## Structure
- Shared package (pipeline_ctrl_pkg) holds:
  - state encodings
  - HALT opcode constant 6'b111111
  - DRAIN_CYCLES default
- Sub-module hazard_detect: purely combinational lu computation, reusable by the forwarding unit.
- Top level contains the FSM, drain counter, cycle counter and output mux.

## Test plan
- Reset, then i_run=1: state goes 0->1 after one edge. All enables=1. After 10 cycles, o_cycle_count=10.
- EX holds a load with i_ex_rt=5 and ID has i_id_rs=5: one cycle with o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1, o_pipe_en=1. With i_ex_rt=0 instead: no stall.
- i_id_branch_taken=1 with no hazard: o_if_id_flush=1, o_pc_en=1. With lu=1 in the same cycle: stall only, flush=0.
- IDLE, three i_step pulses 4 cycles apart: o_pipe_en high for exactly 3 single cycles. o_cycle_count=3. State returns to 0 after each pulse.
- i_id_halt in RUN: the next 3 cycles are DRAIN (o_pipe_en=1, o_pc_en=0), then o_halted=1 and state=4. A later i_run toggle causes no change.
- Assert i_rst_n=0 during DRAIN: outputs return to reset values asynchronously. o_cycle_count=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared definitions for the five-stage pipeline sequencer and anything
//   else that needs to agree with it, such as the forwarding unit or the
//   debug unit.
//
//   Contents:
//     ctrl_state_t         - sequencer state encoding, visible on o_state
//     HALT_OPCODE          - opcode the decoder flags as HALT
//     DRAIN_CYCLES_DEFAULT - stages behind ID that must empty after HALT
//     COUNT_W_DEFAULT      - default width of the executed-cycle counter
//     is_halt_opcode()     - helper for decoders that need the same test
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  // The encoding is visible to the debug unit through o_state, so these
  // values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  // After HALT leaves ID, the EX, MEM and WB stages still hold live work.
  localparam int DRAIN_CYCLES_DEFAULT = 3;

  localparam int COUNT_W_DEFAULT = 32;

  function automatic logic is_halt_opcode(input logic [5:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Purely combinational load-use hazard detector. The hazard is flagged when
//   the instruction in EX is a load whose destination is a source register
//   of the instruction in ID. Register 0 never causes a hazard because it is
//   hard-wired to zero. The forwarding unit can reuse this module unchanged.
//
//   Ports:
//     ex_mem_op   in  1  EX instruction is a memory op
//     ex_mem_type in  1  0 = load, 1 = store
//     ex_rt       in  5  destination rt of the EX instruction
//     id_rs       in  5  rs field of the ID instruction
//     id_rt       in  5  rt field of the ID instruction
//     id_uses_rt  in  1  ID instruction actually reads rt
//     load_use    out 1  stall required this cycle
// ---------------------------------------------------------------------------
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_mem_op,
  input  logic       ex_mem_type,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic ex_is_load;
  logic rs_match;
  logic rt_match;

  // An rt match only matters when the ID instruction really reads rt.
  // For I-type ALU ops and loads, rt is a destination, not a source.
  always_comb begin
    ex_is_load = ex_mem_op && !ex_mem_type;
    rs_match   = (ex_rt == id_rs);
    rt_match   = id_uses_rt && (ex_rt == id_rt);
    load_use   = ex_is_load && (ex_rt != 5'd0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
//   Central sequencer for the five-stage MIPS pipeline. It produces the
//   per-stage advance, flush and bubble controls. It also runs the debug
//   state machine, which has five states: idle, free-run, single-step,
//   drain after HALT, and done.
//
//   Parameters:
//     DRAIN_CYCLES  cycles the pipe keeps advancing after HALT leaves ID
//     COUNT_W       width of the executed-cycle counter
//
//   Ports:
//     i_clk, i_rst_n     clock (rising edge), async active-low reset
//     i_run              level, free-run requested
//     i_step             one-cycle pulse, request one pipeline advance
//     i_id_halt          ID holds HALT
//     i_id_rs, i_id_rt   source fields of the ID instruction
//     i_id_uses_rt       ID instruction reads rt
//     i_id_branch_taken  jump or branch resolved taken in ID
//     i_ex_mem_op        EX is a memory op
//     i_ex_mem_type      0 load, 1 store
//     i_ex_rt            destination rt of the EX instruction
//     o_pc_en            PC loads its next value
//     o_if_id_en         IF/ID captures
//     o_if_id_flush      IF/ID loads NOP
//     o_id_ex_bubble     ID/EX loads NOP
//     o_pipe_en          ID/EX, EX/MEM and MEM/WB advance
//     o_state            current sequencer state
//     o_halted           program finished and pipeline drained
//     o_cycle_count      number of cycles with o_pipe_en high
// ---------------------------------------------------------------------------
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int COUNT_W      = COUNT_W_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_id_halt,
  input  logic [4:0]         i_id_rs,
  input  logic [4:0]         i_id_rt,
  input  logic               i_id_uses_rt,
  input  logic               i_id_branch_taken,
  input  logic               i_ex_mem_op,
  input  logic               i_ex_mem_type,
  input  logic [4:0]         i_ex_rt,
  output logic               o_pc_en,
  output logic               o_if_id_en,
  output logic               o_if_id_flush,
  output logic               o_id_ex_bubble,
  output logic               o_pipe_en,
  output logic [2:0]         o_state,
  output logic               o_halted,
  output logic [COUNT_W-1:0] o_cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  ctrl_state_t        state, state_next;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_next;
  logic [COUNT_W-1:0] cycle_count;
  logic               load_use;

  hazard_detect u_hazard_detect (
    .ex_mem_op   (i_ex_mem_op),
    .ex_mem_type (i_ex_mem_type),
    .ex_rt       (i_ex_rt),
    .id_rs       (i_id_rs),
    .id_rt       (i_id_rt),
    .id_uses_rt  (i_id_uses_rt),
    .load_use    (load_use)
  );

  // State, drain counter and cycle counter registers. The cycle counter
  // follows o_pipe_en directly, so bubble and drain cycles count as
  // executed cycles. It wraps naturally at 2^COUNT_W.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      drain_cnt   <= '0;
      cycle_count <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      if (o_pipe_en) begin
        cycle_count <= cycle_count + COUNT_W'(1);
      end
    end
  end

  // Next-state and output decode.
  //
  // While advancing, there is a fixed priority. A load-use stall comes first
  // and hides HALT and branches in ID, because the ID instruction is held
  // and will be seen again next cycle. HALT comes next and takes over from
  // both the run-release and the single-step return to IDLE. Otherwise the
  // instruction would stay stuck in ID with the pipeline only half emptied.
  // The decoder never flags HALT and a taken branch together, so their
  // relative order only needs to be fixed, not meaningful.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_en      = 1'b0;
    o_halted       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_run) begin
          state_next = ST_RUN;
        end else if (i_step) begin
          state_next = ST_STEP;
        end
      end

      ST_RUN, ST_STEP: begin
        o_pipe_en  = 1'b1;
        state_next = (state == ST_RUN && i_run) ? ST_RUN : ST_IDLE;
        if (load_use) begin
          o_id_ex_bubble = 1'b1;
        end else if (i_id_halt) begin
          o_if_id_flush  = 1'b1;
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_W'(DRAIN_CYCLES);
        end else if (i_id_branch_taken) begin
          o_pc_en       = 1'b1;
          o_if_id_flush = 1'b1;
        end else begin
          o_pc_en    = 1'b1;
          o_if_id_en = 1'b1;
        end
      end

      // Keep the back half moving and feed NOPs in behind HALT. The
      // comparison is "<= 1" so that a zero-length drain also ends.
      ST_DRAIN: begin
        o_pipe_en      = 1'b1;
        o_if_id_flush  = 1'b1;
        drain_cnt_next = drain_cnt - DRAIN_W'(1);
        if (drain_cnt <= DRAIN_W'(1)) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        o_halted = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_state       = state;
  assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pipeline_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_controller
//   Self-checking bench for pipeline_controller. It runs directed steps and
//   then a randomized stretch. Every cycle, the outputs are compared against
//   a behavioural model of the run/step/halt rules.
// ---------------------------------------------------------------------------
module tb_pipeline_controller;

  localparam int DRAIN   = 3;
  localparam int COUNT_W = 32;

  logic               i_clk;
  logic               i_rst_n;
  logic               i_run;
  logic               i_step;
  logic               i_id_halt;
  logic [4:0]         i_id_rs;
  logic [4:0]         i_id_rt;
  logic               i_id_uses_rt;
  logic               i_id_branch_taken;
  logic               i_ex_mem_op;
  logic               i_ex_mem_type;
  logic [4:0]         i_ex_rt;
  logic               o_pc_en;
  logic               o_if_id_en;
  logic               o_if_id_flush;
  logic               o_id_ex_bubble;
  logic               o_pipe_en;
  logic [2:0]         o_state;
  logic               o_halted;
  logic [COUNT_W-1:0] o_cycle_count;

  int checks   = 0;
  int failures = 0;

  // Model state: mode 0 idle, 1 run, 2 step, 3 drain, 4 done.
  int          m_mode;
  int          m_drain_left;
  logic [31:0] m_count;
  logic        e_pc, e_ifid, e_flush, e_bubble, e_pipe, e_halted;

  pipeline_controller #(.DRAIN_CYCLES(DRAIN), .COUNT_W(COUNT_W)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_run             (i_run),
    .i_step            (i_step),
    .i_id_halt         (i_id_halt),
    .i_id_rs           (i_id_rs),
    .i_id_rt           (i_id_rt),
    .i_id_uses_rt      (i_id_uses_rt),
    .i_id_branch_taken (i_id_branch_taken),
    .i_ex_mem_op       (i_ex_mem_op),
    .i_ex_mem_type     (i_ex_mem_type),
    .i_ex_rt           (i_ex_rt),
    .o_pc_en           (o_pc_en),
    .o_if_id_en        (o_if_id_en),
    .o_if_id_flush     (o_if_id_flush),
    .o_id_ex_bubble    (o_id_ex_bubble),
    .o_pipe_en         (o_pipe_en),
    .o_state           (o_state),
    .o_halted          (o_halted),
    .o_cycle_count     (o_cycle_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    i_run = 0; i_step = 0; i_id_halt = 0; i_id_rs = 0; i_id_rt = 0;
    i_id_uses_rt = 0; i_id_branch_taken = 0; i_ex_mem_op = 0;
    i_ex_mem_type = 0; i_ex_rt = 0;
  endtask

  task automatic modelReset();
    m_mode = 0; m_drain_left = 0; m_count = 0;
  endtask

  // Expected combinational controls for the current mode and inputs.
  task automatic modelOutputs();
    logic lu;
    logic adv;
    lu = i_ex_mem_op && !i_ex_mem_type && (i_ex_rt != 0) &&
         ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
    adv = (m_mode == 1) || (m_mode == 2);
    e_pc = 0; e_ifid = 0; e_flush = 0; e_bubble = 0; e_pipe = 0; e_halted = 0;
    if (adv) begin
      e_pipe = 1;
      if (lu) e_bubble = 1;
      else if (i_id_halt) e_flush = 1;
      else if (i_id_branch_taken) begin e_pc = 1; e_flush = 1; end
      else begin e_pc = 1; e_ifid = 1; end
    end
    if (m_mode == 3) begin e_pipe = 1; e_flush = 1; end
    if (m_mode == 4) e_halted = 1;
  endtask

  // Apply one rising edge to the model. The expected outputs must already
  // have been computed for this cycle.
  task automatic modelEdge();
    logic halting;
    halting = ((m_mode == 1) || (m_mode == 2)) && !e_bubble && i_id_halt;
    if (e_pipe) m_count = m_count + 1;
    if (m_mode == 0) begin
      if (i_run) m_mode = 1;
      else if (i_step) m_mode = 2;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (halting) begin
        m_mode = 3; m_drain_left = DRAIN;
      end else if (m_mode == 2 || !i_run) begin
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      m_drain_left = m_drain_left - 1;
      if (m_drain_left == 0) m_mode = 4;
    end
  endtask

  task automatic checkAll(input string tag);
    modelOutputs();
    checkOutput({tag, ".pc_en"},  32'(o_pc_en),        32'(e_pc));
    checkOutput({tag, ".if_en"},  32'(o_if_id_en),     32'(e_ifid));
    checkOutput({tag, ".flush"},  32'(o_if_id_flush),  32'(e_flush));
    checkOutput({tag, ".bubble"}, 32'(o_id_ex_bubble), 32'(e_bubble));
    checkOutput({tag, ".pipe"},   32'(o_pipe_en),      32'(e_pipe));
    checkOutput({tag, ".halted"}, 32'(o_halted),       32'(e_halted));
    checkOutput({tag, ".state"},  32'(o_state),        32'(m_mode));
    checkOutput({tag, ".count"},  o_cycle_count,       m_count);
  endtask

  // One clock cycle with the current inputs. Outputs are checked on the
  // falling edge, and the new inputs may be driven 1 ns after the rising edge.
  task automatic applyStimulus(input string tag);
    @(negedge i_clk);
    checkAll(tag);
    @(posedge i_clk);
    modelEdge();
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".pc_en"},  32'(o_pc_en),        0);
    checkOutput({tag, ".if_en"},  32'(o_if_id_en),     0);
    checkOutput({tag, ".flush"},  32'(o_if_id_flush),  0);
    checkOutput({tag, ".bubble"}, 32'(o_id_ex_bubble), 0);
    checkOutput({tag, ".pipe"},   32'(o_pipe_en),      0);
    checkOutput({tag, ".halted"}, 32'(o_halted),       0);
    checkOutput({tag, ".state"},  32'(o_state),        0);
    checkOutput({tag, ".count"},  o_cycle_count,       0);
  endtask

  // Assert reset mid-cycle, away from any edge, and check it takes effect at once.
  task automatic asyncReset(input string tag);
    clearInputs();
    #2 i_rst_n = 0;
    #1 checkResetValues(tag);
    modelReset();
    @(negedge i_clk);
    i_rst_n = 1;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [31:0] base;
    clearInputs();
    modelReset();

    // Reset values.
    i_rst_n = 0;
    #12 checkResetValues("reset");
    @(negedge i_clk);
    i_rst_n = 1;
    @(posedge i_clk);
    #1;

    // Free run: one edge to enter RUN, then 10 counted cycles.
    i_run = 1;
    applyStimulus("run_start");
    checkOutput("state_run", 32'(o_state), 1);
    repeat (10) applyStimulus("run");
    checkOutput("count_10", o_cycle_count, 10);

    // Load-use on rs.
    i_ex_mem_op = 1; i_ex_mem_type = 0; i_ex_rt = 5; i_id_rs = 5;
    #1;
    checkOutput("lu_pc_en", 32'(o_pc_en), 0);
    checkOutput("lu_bubble", 32'(o_id_ex_bubble), 1);
    applyStimulus("lu_rs");

    // rt == 0 never stalls.
    i_ex_rt = 0; i_id_rs = 0;
    #1;
    checkOutput("rt0_bubble", 32'(o_id_ex_bubble), 0);
    applyStimulus("lu_zero");

    // Store to the same register: no stall.
    i_ex_mem_type = 1; i_ex_rt = 5; i_id_rs = 5;
    applyStimulus("store_nolu");

    // Taken branch, no hazard.
    clearInputs(); i_run = 1; i_id_branch_taken = 1;
    #1;
    checkOutput("br_flush", 32'(o_if_id_flush), 1);
    checkOutput("br_pc_en", 32'(o_pc_en), 1);
    applyStimulus("branch");

    // Taken branch together with a load-use on rt: stall only.
    i_ex_mem_op = 1; i_ex_rt = 7; i_id_rt = 7; i_id_uses_rt = 1;
    #1;
    checkOutput("brlu_flush", 32'(o_if_id_flush), 0);
    applyStimulus("branch_lu");

    // Same rt but ID does not read it: no stall.
    i_id_uses_rt = 0;
    applyStimulus("branch_rt_unused");

    // Back to IDLE, then three single steps four cycles apart.
    clearInputs();
    applyStimulus("run_stop");
    checkOutput("state_idle", 32'(o_state), 0);
    base = o_cycle_count;
    for (int k = 0; k < 3; k++) begin
      i_step = 1;
      applyStimulus("step_pulse");
      i_step = 0;
      checkOutput("state_step", 32'(o_state), 2);
      repeat (4) applyStimulus("step_gap");
      checkOutput("state_step_back", 32'(o_state), 0);
    end
    checkOutput("step_count", o_cycle_count - base, 3);

    // Randomized run/step/hazard/branch traffic with no HALT.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) i_run = ~i_run;
      i_step            = ($urandom_range(0, 3) == 0);
      i_ex_mem_op       = 1'($urandom);
      i_ex_mem_type     = 1'($urandom);
      i_ex_rt           = 5'($urandom_range(0, 3));
      i_id_rs           = 5'($urandom_range(0, 3));
      i_id_rt           = 5'($urandom_range(0, 3));
      i_id_uses_rt      = 1'($urandom);
      i_id_branch_taken = ($urandom_range(0, 2) == 0);
      i_id_halt         = 0;
      applyStimulus("random");
    end

    // HALT behind a load-use stall is ignored.
    clearInputs(); i_run = 1;
    repeat (3) applyStimulus("rerun");
    i_id_halt = 1; i_ex_mem_op = 1; i_ex_rt = 2; i_id_rs = 2;
    applyStimulus("halt_lu");
    checkOutput("halt_lu_state", 32'(o_state), 1);

    // HALT in RUN, with i_run dropping in the same cycle: drain, then done.
    clearInputs(); i_id_halt = 1;
    applyStimulus("halt");
    i_id_halt = 0;
    checkOutput("drain_state", 32'(o_state), 3);
    repeat (DRAIN) applyStimulus("drain");
    checkOutput("done_state", 32'(o_state), 4);
    checkOutput("done_halted", 32'(o_halted), 1);
    i_run = 1; applyStimulus("done_run_hi");
    i_run = 0; applyStimulus("done_run_lo");
    i_step = 1; applyStimulus("done_step");
    i_step = 0;
    checkOutput("done_stays", 32'(o_state), 4);

    // Reset out of DONE.
    asyncReset("reset_done");

    // Step into HALT, then reset mid-DRAIN.
    i_step = 1; applyStimulus("step2");
    i_step = 0; i_id_halt = 1; applyStimulus("step_halt");
    i_id_halt = 0;
    checkOutput("step_drain_state", 32'(o_state), 3);
    applyStimulus("drain2");
    asyncReset("reset_drain");
    applyStimulus("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
